cordic_vectoring: RTL and testbench

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_vectoring.sv | 73 +++++++
 tb/tb_cordic_vectoring.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC in vectoring mode, (x,y) -> gain-compensated magnitude and atan2 angle
module cordic_vectoring #(
  parameter int ITERATIONS = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] magnitude,
  output logic signed [31:0] angle
);
  typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;
  // atan(2^-i) with 2^28 = 45 degrees; entry 31 is never reached
  localparam logic [31:0] ATAN [32] = '{
    32'h10000000, 32'h0972028F, 32'h04FD9C2E, 32'h028888EA, 32'h014586A2, 32'h00A2EBF1,
    32'h00517B0F, 32'h0028BE2B, 32'h00145F2A, 32'h000A2F97, 32'h000517CC, 32'h00028BE6,
    32'h000145F3, 32'h0000A2FA, 32'h0000517D, 32'h000028BE, 32'h0000145F, 32'h00000A30,
    32'h00000518, 32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051, 32'h00000029,
    32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001, 32'h00000001,
    32'h00000000, 32'h00000000
  };
  localparam logic signed [33:0] MAG_MAX = 34'sh0_7FFF_FFFF;
  state_t state, state_nxt;
  logic signed [33:0] x, y, x_ext, y_ext, x_sh, y_sh, m;
  logic [31:0] z;
  logic [4:0] i;
  logic zero;
  assign busy  = state != IDLE;
  assign x_ext = {{2{x_in[31]}}, x_in};
  assign y_ext = {{2{y_in[31]}}, y_in};
  assign x_sh  = x >>> i;
  assign y_sh  = y >>> i;
  assign m     = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
  always_comb begin
    state_nxt = (state == IDLE) ? (start ? ITER : IDLE) :
                (state == ITER) ? ((i == 5'(ITERATIONS - 1)) ? SCALE : ITER) : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      magnitude <= '0;
      angle     <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      zero      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= state == SCALE;
      if (state == IDLE && start) begin
        // left half-plane vectors are mirrored into the right half-plane by +/-180 degrees
        x    <= x_in[31] ? -x_ext : x_ext;
        y    <= x_in[31] ? -y_ext : y_ext;
        z    <= !x_in[31] ? '0 : y_in[31] ? 32'hC000_0000 : 32'h4000_0000;
        i    <= '0;
        zero <= x_in == 0 && y_in == 0;
      end else if (state == ITER) begin
        x <= y[33] ? x - y_sh : x + y_sh;
        y <= y[33] ? y + x_sh : y - x_sh;
        z <= y[33] ? z - ATAN[i] : z + ATAN[i];
        i <= i + 5'd1;
      end else if (state == SCALE) begin
        magnitude <= (m > MAG_MAX) ? 32'sh7FFF_FFFF : m[31:0];
        angle     <= zero ? '0 : z;
      end
    end
  end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: random and directed conversions checked every cycle against a latency/arithmetic model
module tb_cordic_vectoring;
  localparam int N = 15;
  logic clock = 1'b0;
  logic reset_n, start;
  logic signed [31:0] x_in, y_in;
  logic busy, done;
  logic signed [31:0] magnitude, angle;
  int vectors = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic e_busy = 1'b0, e_done = 1'b0;
  logic signed [31:0] e_mag = '0, e_ang = '0, p_mag = '0, p_ang = '0;
  int left = 0;

  cordic_vectoring #(.ITERATIONS(N)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .magnitude(magnitude), .angle(angle)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] atan_lut(input int k);
    real v = $atan($pow(2.0, -k)) * 1073741824.0 / 3.14159265358979323846;
    return 32'($rtoi(v + 0.5));
  endfunction

  function automatic logic [63:0] ref_fn(input logic signed [31:0] xi, input logic signed [31:0] yi);
    longint x, y, t, m;
    logic [31:0] z;
    if (xi == 0 && yi == 0) return 64'd0;
    x = xi;
    y = yi;
    z = '0;
    if (xi < 0) begin
      x = -x;
      y = -y;
      z = (yi < 0) ? 32'hC000_0000 : 32'h4000_0000;
    end
    for (int k = 0; k < N; k++) begin
      t = x;
      if (y >= 0) begin
        x = x + (y >>> k); y = y - (t >>> k); z = z + atan_lut(k);
      end else begin
        x = x - (y >>> k); y = y + (t >>> k); z = z - atan_lut(k);
      end
    end
    m = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    if (m > 64'sh7FFF_FFFF) m = 64'sh7FFF_FFFF;
    return {m[31:0], z};
  endfunction

  // model: results appear N+1 edges after the accepting edge
  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      e_busy = 0; e_done = 0; e_mag = 0; e_ang = 0; left = 0;
    end else begin
      e_done = 0;
      if (e_busy) begin
        left--;
        if (left == 0) begin
          e_busy = 0; e_done = 1; e_mag = p_mag; e_ang = p_ang;
        end
      end else if (start) begin
        e_busy = 1;
        left = N + 1;
        {p_mag, p_ang} = ref_fn(x_in, y_in);
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      vectors++;
      if (busy !== e_busy || done !== e_done || magnitude !== e_mag || angle !== e_ang) begin
        errors++;
        $display("FAIL cycle t=%0t: busy %b want %b, done %b want %b, mag %h want %h, angle %h want %h",
                 $time, busy, e_busy, done, e_done, magnitude, e_mag, angle, e_ang);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    longint d = act - exp;
    vectors++;
    if (d < -tol || d > tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_ang(input string name, input logic [31:0] act, input logic [31:0] exp);
    logic [31:0] w = act - exp;
    longint d = longint'($signed(w));
    vectors++;
    if (d < -longint'(32'hA300) || d > longint'(32'hA300)) begin
      errors++;
      $display("FAIL %s: got %h want %h (tol A300)", name, act, exp);
    end
  endtask

  task automatic run(input logic signed [31:0] xv, input logic signed [31:0] yv,
                     output logic signed [31:0] mag, output logic signed [31:0] ang, output int lat);
    x_in = xv;
    y_in = yv;
    start = 1;
    @(negedge clock);
    start = 0;
    lat = -1;
    for (int k = 2; k <= 100; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k - 1;
        break;
      end
    end
    mag = magnitude;
    ang = angle;
    if (lat < 0) check("done_timeout", lat, N + 1, 0);
  endtask

  initial begin
    logic signed [31:0] mg, an;
    logic [63:0] r;
    int lat;
    logic saw;
    reset_n = 0; start = 0; x_in = 0; y_in = 0;
    r = ref_fn(1000000, 0);
    check("model_x_mag", longint'($signed(r[63:32])), 1000270, 2000);
    check_ang("model_x_ang", r[31:0], 32'h0);
    r = ref_fn(-1000000, 1000000);
    check_ang("model_q2_ang", r[31:0], 32'h3000_0000);
    repeat (3) @(negedge clock);
    chk_en = 1;
    @(negedge clock);
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_mag", magnitude, 0, 0);
    check("rst_ang", angle, 0, 0);
    reset_n = 1;
    run(1000000, 0, mg, an, lat);
    check("x_lat", lat, 16, 0);
    check("x_mag", mg, 1000270, 2000);
    check_ang("x_ang", an, 32'h0);
    run(0, 1000000, mg, an, lat);
    check("y_lat_b2b", lat, 16, 0);
    check("y_mag", mg, 1000270, 2000);
    check_ang("y_ang", an, 32'h2000_0000);
    run(-1000000, -1000000, mg, an, lat);
    check("q3_mag", mg, 1414596, 2829);
    check_ang("q3_ang", an, 32'hD000_0000);
    run(0, 0, mg, an, lat);
    check("zero_lat", lat, 16, 0);
    check("zero_mag", mg, 0, 0);
    check("zero_ang", an, 0, 0);
    run(32'sh7FFF_FFFF, 32'sh7FFF_FFFF, mg, an, lat);
    check("sat_mag", mg, 32'h7FFF_FFFF, 0);
    check_ang("sat_ang", an, 32'h1000_0000);
    run(32'sh8000_0000, 0, mg, an, lat);
    check("neg_min_mag", mg, 32'h7FFF_FFFF, 0);
    check_ang("neg_min_ang", an, 32'h4000_0000);
    x_in = 1000000; y_in = 500000; start = 1;
    @(negedge clock);
    start = 0;
    @(negedge clock);
    x_in = -5; y_in = 7; start = 1;
    @(negedge clock);
    start = 0;
    repeat (5) @(negedge clock);
    #1 reset_n = 0;
    @(negedge clock);
    check("midrst_busy", busy, 0, 0);
    check("midrst_mag", magnitude, 0, 0);
    check("midrst_ang", angle, 0, 0);
    reset_n = 1;
    saw = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) saw = 1;
    end
    check("midrst_no_done", saw, 0, 0);
    run(1000000, 0, mg, an, lat);
    check("post_rst_lat", lat, 16, 0);
    check("post_rst_mag", mg, 1000270, 2000);
    for (int n = 0; n < 40; n++) begin
      logic signed [31:0] xr, yr;
      xr = $urandom;
      yr = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin xr = xr >>> 12; yr = yr >>> 12; end
        2: xr = ($urandom_range(0, 1) != 0) ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        default: begin xr = xr >>> 28; yr = yr >>> 28; end
      endcase
      run(xr, yr, mg, an, lat);
      check("rand_lat", lat, 16, 0);
    end
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
